cordic_sqrt_sched: RTL
======================

// Module: cordic_sqrt_sched
// PURPOSE
//  Round-robin scheduler that shares one SQRT_POWSUM CORDIC engine (magnitude/phase) between
//  N_CH requesters, e.g. the I/Q ADC channel pairs of the cost-function path.
//  Per job: grants one requester, registers its X/Y/OFFSET onto the engine, pulses the engine
//  enable low->high to restart it, waits for done, captures FOUT/POUT and returns them tagged.
//  A watchdog aborts hung jobs.
// PARAMETERS
//  N_CH        4     number of requesters (2..8)
//  DW          13    engine operand/result width (MAX_SQRT_WIDTH)
//  OW          10    offset width (CADC_WIDTH)
//  TIMEOUT_CYC 255   max RUN cycles before abort (>=1); counter width = $clog2(TIMEOUT_CYC+1)
// PORTS
//  CLK         in   1         clock, all logic on rising edge
//  RST_N       in   1         reset, synchronous, active-low
//  sched_en    in   1         0: no new grants; in-flight job still completes
//  req         in   N_CH      level request per channel
//  x_bus       in   N_CH*DW   X operands, channel i at [i*DW +: DW]
//  y_bus       in   N_CH*DW   Y operands, same packing
//  off_bus     in   N_CH*OW   offsets, channel i at [i*OW +: OW]
//  busy        out  1         1 in any state except IDLE
//  res_valid   out  1         one-cycle pulse, result fields valid
//  res_id      out  $clog2(N_CH)  channel of the result
//  res_mag     out  DW        captured eng_fout (0 on abort)
//  res_phase   out  DW        captured eng_pout (0 on abort)
//  res_err     out  1         1 with res_valid when job was aborted by watchdog
//  eng_enable  out  1         engine enable (engine clears itself while 0)
//  eng_x, eng_y out DW        registered operands to engine
//  eng_offset  out  OW        registered offset to engine
//  eng_fout    in   DW        engine magnitude
//  eng_pout    in   DW        engine phase
//  eng_done    in   1         engine done level (held while engine enabled)
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state IDLE; busy/res_valid/res_err/eng_enable=0; res_mag/res_phase/
//   res_id/eng_x/eng_y/eng_offset=0; rr pointer=N_CH-1 (channel 0 wins first). Reset mid-job
//   abandons it; no res_valid is produced.
//  FSM, all outputs registered:
//   IDLE: eng_enable=0. If sched_en & |req: grant = first set req scanning ptr+1, ptr+2, ...
//     (mod N_CH); latch grant id, load eng_x/eng_y/eng_offset from its slices; ptr<=grant; ->LOAD.
//   LOAD: eng_enable=0 one cycle (guarantees engine restart with stable operands); clear
//     watchdog; ->RUN.
//   RUN: eng_enable=1; watchdog counts each cycle. eng_done=1 -> capture eng_fout/eng_pout,
//     res_err=0, ->DONE. Else if count==TIMEOUT_CYC-1 -> res_mag=res_phase=0, res_err=1, ->DONE.
//     eng_done and timeout in same cycle: done wins.
//   DONE: res_valid=1 for exactly this cycle, res_id=grant; eng_enable=0; ->IDLE.
//  eng_done is ignored outside RUN (stale done from previous job cannot complete a new one).
//  Operands are sampled only in IDLE; requester changes after grant do not affect the job.
//  Requester holds req until it sees res_valid with its id and drops req the next cycle;
//   a req still high in the following IDLE is a new job.
//  req dropped after grant: job still runs and reports.
//  Latency: grant cycle t, result pulse t+3+E, E = engine cycles from enable to done.
//  Fairness: with all req high, grants rotate 0,1,..,N_CH-1,0; no channel waits >N_CH-1 jobs.
//  res_* fields hold their value between pulses; only res_valid qualifies them.
// TESTING
//  1 Single req[2], x=100,y=50,off=10; stub done after 40 cyc, fout=77,pout=12 -> eng_x=100,
//    eng_offset=10; eng_enable 0 in LOAD; res_valid at t+43, id=2, mag=77, phase=12, err=0.
//  2 All 4 req held high, stub E=20 -> res_id sequence 0,1,2,3,0; spacing 24 cyc; busy
//    low 1 cyc between jobs.
//  3 Stub never asserts done, TIMEOUT_CYC=255 -> res_valid 255 cyc after RUN entry, err=1,
//    mag=phase=0; next req still served normally.
//  4 eng_done held 1 from stale job while in IDLE/LOAD -> ignored; completion only via RUN.
//  5 RST_N=0 for 1 cycle mid-RUN -> next cycle IDLE, eng_enable=0, no res_valid; next grant
//    goes to channel 0.
//  6 sched_en dropped during RUN -> current job reports; no further grants until sched_en=1.

Source files
------------

// File: rtl/cordic_sqrt_sched.sv
// cordic_sqrt_sched: round-robin scheduler sharing one CORDIC magnitude/phase engine among N_CH requesters,
// with a registered engine interface and a watchdog that aborts hung jobs.
module cordic_sqrt_sched #(
  parameter int N_CH        = 4,
  parameter int DW          = 13,
  parameter int OW          = 10,
  parameter int TIMEOUT_CYC = 255,
  localparam int IW = $clog2(N_CH),
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              sched_en,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*DW-1:0] x_bus,
  input  logic [N_CH*DW-1:0] y_bus,
  input  logic [N_CH*OW-1:0] off_bus,
  output logic              busy,
  output logic              res_valid,
  output logic [IW-1:0]     res_id,
  output logic [DW-1:0]     res_mag,
  output logic [DW-1:0]     res_phase,
  output logic              res_err,
  output logic              eng_enable,
  output logic [DW-1:0]     eng_x,
  output logic [DW-1:0]     eng_y,
  output logic [OW-1:0]     eng_offset,
  input  logic [DW-1:0]     eng_fout,
  input  logic [DW-1:0]     eng_pout,
  input  logic              eng_done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, id_q, id_d, pick, cand;
  logic [DW-1:0] x_q, x_d, y_q, y_d, mag_q, mag_d, ph_q, ph_d;
  logic [OW-1:0] off_q, off_d;
  logic [CW-1:0] wd_q, wd_d;
  logic err_q, err_d, en_q, valid_q, busy_q, hit;
  // Rotating priority: the channel after the last grant is scanned first.
  always_comb begin
    hit = 1'b0;
    pick = ptr_q;
    cand = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_CH);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    id_d = id_q;
    x_d = x_q;
    y_d = y_q;
    off_d = off_q;
    wd_d = wd_q;
    mag_d = mag_q;
    ph_d = ph_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (sched_en && hit) begin
        state_d = LOAD;
        gnt_d = pick;
        ptr_d = pick;
        x_d = x_bus[pick*DW +: DW];
        y_d = y_bus[pick*DW +: DW];
        off_d = off_bus[pick*OW +: OW];
      end
      LOAD: begin
        wd_d = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = wd_q + CW'(1);
        if (eng_done) begin
          mag_d = eng_fout;
          ph_d = eng_pout;
          err_d = 1'b0;
          id_d = gnt_q;
          state_d = DONE;
        end else if (wd_q == CW'(TIMEOUT_CYC - 1)) begin
          mag_d = '0;
          ph_d = '0;
          err_d = 1'b1;
          id_d = gnt_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_CH - 1);
      gnt_q <= '0;
      id_q <= '0;
      x_q <= '0;
      y_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      mag_q <= '0;
      ph_q <= '0;
      err_q <= 1'b0;
      en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      x_q <= x_d;
      y_q <= y_d;
      off_q <= off_d;
      wd_q <= wd_d;
      mag_q <= mag_d;
      ph_q <= ph_d;
      err_q <= err_d;
      en_q <= state_d == RUN;
      valid_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
  end
  assign busy = busy_q;
  assign res_valid = valid_q;
  assign res_id = id_q;
  assign res_mag = mag_q;
  assign res_phase = ph_q;
  assign res_err = err_q;
  assign eng_enable = en_q;
  assign eng_x = x_q;
  assign eng_y = y_q;
  assign eng_offset = off_q;
endmodule
